// File: rtl/comp_seq_ctrl.sv
// Wide unsigned magnitude compare: one shared 2-bit slice walked MSB-first, one slice per clock.
// Latency: k edges after accepting start (k = first differing slice, NS if equal) or NS when EARLY_EXIT=0.
// Backpressure: start is only taken while busy=0; a start seen while busy is dropped, never queued.
module comp_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g
);

    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COMPARE = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx;
    logic             decided;
    logic             dec_lt;
    logic             dec_gt;

    logic [1:0] sl_a;
    logic [1:0] sl_b;
    logic       sl_lt;
    logic       sl_gt;
    logic       sl_ne;
    logic       last_slice;
    logic       finish;
    logic       fin_lt;
    logic       fin_gt;

    // Current slice is selected by shifting the latched words down by 2*idx.
    always_comb begin
        sl_a       = 2'(a_r >> {idx, 1'b0});
        sl_b       = 2'(b_r >> {idx, 1'b0});
        sl_lt      = (sl_a < sl_b);
        sl_gt      = (sl_a > sl_b);
        sl_ne      = sl_lt | sl_gt;
        last_slice = (idx == '0);
        finish     = (EARLY_EXIT && sl_ne) || last_slice;
        // A decision recorded on an earlier slice always wins over the current one.
        fin_lt     = decided ? dec_lt : sl_lt;
        fin_gt     = decided ? dec_gt : sl_gt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            dec_lt  <= 1'b0;
            dec_gt  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            l       <= 1'b0;
            e       <= 1'b0;
            g       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        idx     <= IW'(NS - 1);
                        decided <= 1'b0;
                        dec_lt  <= 1'b0;
                        dec_gt  <= 1'b0;
                        l       <= 1'b0;
                        e       <= 1'b0;
                        g       <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (!decided && sl_ne) begin
                        decided <= 1'b1;
                        dec_lt  <= sl_lt;
                        dec_gt  <= sl_gt;
                    end
                    if (finish) begin
                        l     <= fin_lt;
                        g     <= fin_gt;
                        e     <= ~(fin_lt | fin_gt);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
